tt_um_uabc_ascii_rx: RTL and testbench
======================================

// Module: tt_um_uabc_ascii_rx
// PURPOSE
//  Receive end of the UABC ASCII character stream: samples an ASCII byte on ui_in per strobe,
//  decodes 'A'..'F','0'..'9' back to the 4-bit symbol index, checks the +1 mod 16 sequence,
//  locks after LOCK_CNT in-order symbols and counts errors. TinyTapeout top-level tile.
// PARAMETERS
//  LOCK_CNT        4           consecutive in-sequence symbols needed to enter LOCKED (2..15)
//  ERR_W           5           width of saturating error counter (drives uio_out[6:2])
//  TIMEOUT_CYCLES  50_000_000  max clk cycles between strobes while LOCKED (TIMEOUT_EN only)
// PORTS
//  clk      in   1  clock
//  rst_n    in   1  reset, asynchronous, active low
//  ena      in   1  always 1; unused
//  ui_in    in   8  ASCII character; stable while uio_in[0] high
//  uio_in   in   8  [0] char strobe (async, rising edge), [1] clear sticky flags/counter; rest unused
//  uo_out   out  8  [3:0] last decoded index, [4] valid pulse, [5] bad-char sticky,
//                   [6] seq-error sticky, [7] locked
//  uio_out  out  8  [6:2] error count, [7] timeout sticky, [1:0] = 0
//  uio_oe   out  8  constant 8'hFC
// BEHAVIOUR
//  Reset: all outputs 0, state HUNT, counters 0, sync flops 0.
//  Strobe: 2-flop sync s1,s2 + delay s3; edge = s2 & ~s3. ui_in captured when edge true;
//   results registered next edge -> outputs change 3 clk edges after strobe first sampled high.
//  Clear: uio_in[1] sampled directly (sync 2-flop); while high clears [5],[6],err count,
//   timeout flag; clear wins over a same-cycle set; state/lock unaffected.
//  Decode: 0x41..0x46 -> 0..5; 0x30..0x39 -> 6..15; all else invalid (lowercase invalid).
//  FSM (state, prev[3:0], run count):
//   HUNT:   valid -> prev=idx, run=1, CHECK.  invalid -> bad flag, err++, stay.
//   CHECK:  valid & idx==prev+1 (mod 16) -> run++; run reaches LOCK_CNT -> LOCKED.
//           valid mismatch -> prev=idx, run=1, stay (no error; not yet locked).
//           invalid -> bad flag, err++, HUNT.
//   LOCKED: valid in-seq -> stay.  valid mismatch -> seq flag, err++, prev=idx, run=1, CHECK.
//           invalid -> bad flag, err++, HUNT.
//  Wrap: prev=15 ('9') followed by 0 ('A') is in sequence.
//  uo_out[3:0] updates on every valid char in any state; holds on invalid.
//  uo_out[4]: exactly one cycle high per valid char; strobe held high = one char only.
//  Error counter saturates at 2**ERR_W-1; never wraps.
//  Strobe edge and clear in same cycle: character processed, flags then cleared.
//  rst_n low mid-stream: immediate return to reset values regardless of strobe.
// CONFIGURATION
//  UABC_RX_TIMEOUT_EN defined: cycle counter reset on every strobe edge and on leaving
//   LOCKED; in LOCKED reaching TIMEOUT_CYCLES -> HUNT, uio_out[7] set, err++.
//  Undefined: no timeout counter; uio_out[7] tied 0; LOCKED held until char error.
// STRUCTURE
//  Package uabc_ascii_pkg: state enum {HUNT,CHECK,LOCKED}, ASCII_A=8'h41, ASCII_0=8'h30,
//   LETTER_CNT=6, symbol-to-ASCII/ASCII-to-symbol functions (shared with the transmitter tile).
//  Sub-module uabc_ascii_decode: combinational ui byte -> {valid, idx[3:0]}.
//  Top: sync/edge detect, FSM, counters, output mux.
// TESTING
//  1 Reset, send 'A','B','C','D' -> uo[3:0]=3, uo[7]=1 after 4th char, err=0.
//  2 Locked, send '9' then 'A' -> idx 15 then 0, stays locked, no flags.
//  3 Locked at 'C', send 'E' -> uo[6]=1, err=1, uo[7]=0; 'F','0','1' more -> relocks.
//  4 Send 0x61 ('a') -> uo[5]=1, err=1, state HUNT, uo[3:0] unchanged; pulse uio_in[1] -> flags,err=0.
//  5 Hold strobe 100 cycles with 'B' -> one valid pulse; 40 invalid chars -> err stays 31.
//  6 TIMEOUT_EN, TIMEOUT_CYCLES=100: lock, idle 100 cycles -> uio_out[7]=1, uo[7]=0; assert
//    rst_n mid-strobe -> all outputs 0.

Source files
------------

// File: rtl/uabc_ascii_pkg.sv
// Shared UABC ASCII definitions: receiver state encoding and the symbol <-> ASCII mapping
// used by both the transmitter and receiver tiles.
package uabc_ascii_pkg;

  localparam int unsigned SYM_W      = 4;
  localparam int unsigned LETTER_CNT = 6;
  localparam logic [7:0]  ASCII_A    = 8'h41;
  localparam logic [7:0]  ASCII_0    = 8'h30;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [SYM_W-1:0] idx;
  } sym_t;

  // Symbols 0..5 map to 'A'..'F', 6..15 map to '0'..'9'.
  function automatic logic [7:0] sym_to_ascii(input logic [SYM_W-1:0] sym);
    if (sym < SYM_W'(LETTER_CNT)) return ASCII_A + 8'(sym);
    else                          return ASCII_0 + 8'(sym - SYM_W'(LETTER_CNT));
  endfunction

  function automatic sym_t ascii_to_sym(input logic [7:0] ch);
    sym_t s;
    s = '0;
    if (ch >= ASCII_A && ch < ASCII_A + 8'(LETTER_CNT)) begin
      s.valid = 1'b1;
      s.idx   = SYM_W'(ch - ASCII_A);
    end else if (ch >= ASCII_0 && ch <= ASCII_0 + 8'd9) begin
      s.valid = 1'b1;
      s.idx   = SYM_W'(ch - ASCII_0) + SYM_W'(LETTER_CNT);
    end
    return s;
  endfunction

endpackage

// File: rtl/uabc_ascii_decode.sv
// Combinational ASCII byte to UABC symbol decoder; anything outside 'A'..'F','0'..'9' is invalid.
module uabc_ascii_decode
  import uabc_ascii_pkg::*;
(
  input  logic [7:0] ch,
  output sym_t       sym_c
);

  assign sym_c = ascii_to_sym(ch);

endmodule

// File: rtl/tt_um_uabc_ascii_rx.sv
// UABC ASCII receiver tile: strobe sync, symbol decode, sequence lock FSM and error counting.
// Optional LOCKED idle timeout is built when UABC_RX_TIMEOUT_EN is defined.
module tt_um_uabc_ascii_rx
  import uabc_ascii_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned ERR_W    = 5
`ifdef UABC_RX_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 50_000_000
`endif
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int unsigned RUN_W = 4;

  logic s1, s2, s3, c1, c2;
  logic strobe_edge, clr;
  logic cap_vld;
  logic [7:0] cap_byte;
  sym_t sym_c;

  state_t state, state_nx;
  logic [SYM_W-1:0] prev, prev_nx, idx, idx_nx;
  logic [RUN_W-1:0] run, run_nx, run_inc;
  logic [ERR_W-1:0] err;
  logic vld, vld_nx, bad, seq, tmo;
  logic bad_set, seq_set, tmo_set, err_inc;
  logic ev_ok, ev_bad, in_seq, tmo_fire;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in[7:2]};

  // Strobe and clear synchronisers; s3 delays s2 for rising-edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {s1, s2, s3} <= 3'b000;
      {c1, c2}     <= 2'b00;
    end else begin
      {s1, s2, s3} <= {uio_in[0], s1, s2};
      {c1, c2}     <= {uio_in[1], c1};
    end
  end

  assign strobe_edge = s2 & ~s3;
  assign clr         = c2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_vld  <= 1'b0;
      cap_byte <= 8'h00;
    end else begin
      cap_vld <= strobe_edge;
      if (strobe_edge) cap_byte <= ui_in;
    end
  end

  uabc_ascii_decode u_decode (
    .ch    (cap_byte),
    .sym_c (sym_c)
  );

  assign ev_ok   = cap_vld &  sym_c.valid;
  assign ev_bad  = cap_vld & ~sym_c.valid;
  assign in_seq  = (sym_c.idx == prev + SYM_W'(1));
  assign run_inc = run + RUN_W'(1);

`ifdef UABC_RX_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic tmo_hit;

  // Idle-cycle counter, only runs while LOCKED and restarts on every strobe edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                tmo_cnt <= '0;
    else if (strobe_edge || state != LOCKED)   tmo_cnt <= '0;
    else if (!tmo_hit)                         tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  assign tmo_hit  = (state == LOCKED) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign tmo_fire = tmo_hit & ~strobe_edge & ~cap_vld;
`else
  assign tmo_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      HUNT:    if (ev_ok) state_nx = CHECK;
      CHECK:   if (ev_bad)                                               state_nx = HUNT;
               else if (ev_ok && in_seq && run_inc == RUN_W'(LOCK_CNT))  state_nx = LOCKED;
      LOCKED:  if (ev_bad)                 state_nx = HUNT;
               else if (ev_ok && !in_seq)  state_nx = CHECK;
               else if (tmo_fire)          state_nx = HUNT;
      default: state_nx = HUNT;
    endcase
  end

  always_comb begin
    prev_nx = prev;
    run_nx  = run;
    idx_nx  = idx;
    vld_nx  = ev_ok;
    bad_set = ev_bad;
    seq_set = 1'b0;
    tmo_set = 1'b0;
    if (ev_ok) begin
      idx_nx  = sym_c.idx;
      prev_nx = sym_c.idx;
    end
    unique case (state)
      HUNT:    if (ev_ok) run_nx = RUN_W'(1);
      CHECK:   if (ev_ok) run_nx = in_seq ? run_inc : RUN_W'(1);
      LOCKED:  if (ev_ok && !in_seq) begin
                 seq_set = 1'b1;
                 run_nx  = RUN_W'(1);
               end else if (tmo_fire) begin
                 tmo_set = 1'b1;
               end
      default: ;
    endcase
    err_inc = bad_set | seq_set | tmo_set;
  end

  // Clear has priority over any same-cycle flag set or count increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= '0;
      run  <= '0;
      idx  <= '0;
      vld  <= 1'b0;
      bad  <= 1'b0;
      seq  <= 1'b0;
      tmo  <= 1'b0;
      err  <= '0;
    end else begin
      prev <= prev_nx;
      run  <= run_nx;
      idx  <= idx_nx;
      vld  <= vld_nx;
      if (clr) begin
        bad <= 1'b0;
        seq <= 1'b0;
        tmo <= 1'b0;
        err <= '0;
      end else begin
        if (bad_set) bad <= 1'b1;
        if (seq_set) seq <= 1'b1;
        if (tmo_set) tmo <= 1'b1;
        if (err_inc && err != '1) err <= err + ERR_W'(1);
      end
    end
  end

  assign uo_out  = {(state == LOCKED), seq, bad, vld, idx};
  assign uio_out = {tmo, 5'(err), 2'b00};
  assign uio_oe  = 8'hFC;

endmodule

// File: tb/tb_tt_um_uabc_ascii_rx.sv
// Bench for the UABC ASCII receiver: fixed vector table, hand-written corner sequences and a
// randomized character stream checked against a behavioural model. Timeout section needs UABC_RX_TIMEOUT_EN.
module tb_tt_um_uabc_ascii_rx;

  localparam int LOCK = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  int tests = 0;
  int fails = 0;
  int pulses = 0;

  string alpha = "ABCDEF0123456789";

  // Reference model state: mode 0=hunting, 1=checking, 2=locked.
  int m_mode, m_prev, m_run, m_idx, m_err;
  bit m_bad, m_seq, m_tmo;

  typedef struct {
    logic [7:0] ch;
    bit         clr_only;
    logic [7:0] uo;
    logic [7:0] uio;
  } vec_t;
  vec_t vecs[$];

`ifdef UABC_RX_TIMEOUT_EN
  tt_um_uabc_ascii_rx #(.LOCK_CNT(LOCK), .ERR_W(5), .TIMEOUT_CYCLES(100)) dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );
`else
  tt_um_uabc_ascii_rx #(.LOCK_CNT(LOCK), .ERR_W(5)) dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );
`endif

  always #5 clk = ~clk;

  always @(negedge clk) if (uo_out[4]) pulses++;

  function automatic int dec(input logic [7:0] ch);
    for (int i = 0; i < 16; i++) if (alpha[i] == ch) return i;
    return -1;
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_prev = 0; m_run = 0; m_idx = 0; m_err = 0;
    m_bad = 0; m_seq = 0; m_tmo = 0;
  endfunction

  function automatic void model_clear();
    m_bad = 0; m_seq = 0; m_tmo = 0; m_err = 0;
  endfunction

  function automatic void bump();
    if (m_err < 31) m_err++;
  endfunction

  function automatic void model_char(input logic [7:0] ch, input bit clr);
    int d;
    d = dec(ch);
    if (d < 0) begin
      m_bad = 1; bump(); m_mode = 0;
    end else begin
      m_idx = d;
      if (m_mode == 0) begin
        m_mode = 1; m_run = 1;
      end else if (d == (m_prev + 1) % 16) begin
        m_run++;
        if (m_mode == 1 && m_run >= LOCK) m_mode = 2;
      end else begin
        if (m_mode == 2) begin m_seq = 1; bump(); end
        m_mode = 1; m_run = 1;
      end
      m_prev = d;
    end
    if (clr) model_clear();
  endfunction

  function automatic logic [7:0] exp_uo();
    return {(m_mode == 2), m_seq, m_bad, 1'b0, 4'(m_idx)};
  endfunction

  function automatic logic [7:0] exp_uio();
    return {m_tmo, 5'(m_err), 2'b00};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] ch, input int hold, input bit with_clr);
    @(posedge clk); #1;
    pulses = 0;
    ui_in = ch;
    if (with_clr) uio_in[1] = 1'b1;
    uio_in[0] = 1'b1;
    repeat (hold) @(posedge clk);
    #1 uio_in[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1 uio_in[1] = 1'b0;
    if (with_clr) repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_clear();
    @(posedge clk); #1 uio_in[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1 uio_in[1] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    model_clear();
  endtask

  task automatic send_check(input string tag, input logic [7:0] ch, input int hold, input bit with_clr);
    send(ch, hold, with_clr);
    model_char(ch, with_clr);
    check({tag, "_uo"}, 32'(uo_out), 32'(exp_uo()));
    check({tag, "_uio"}, 32'(uio_out), 32'(exp_uio()));
    check({tag, "_pulse"}, 32'(pulses), (dec(ch) >= 0) ? 32'd1 : 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    uio_in = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    logic [7:0] ch;
    int r;

    // Lock on A..D, run through the wrap 9->A, then a sequence error, relock, bad char, clear.
    vecs.push_back('{8'h41, 1'b0, 8'h00, 8'h00});
    vecs.push_back('{8'h42, 1'b0, 8'h01, 8'h00});
    vecs.push_back('{8'h43, 1'b0, 8'h02, 8'h00});
    vecs.push_back('{8'h44, 1'b0, 8'h83, 8'h00});
    vecs.push_back('{8'h45, 1'b0, 8'h84, 8'h00});
    vecs.push_back('{8'h46, 1'b0, 8'h85, 8'h00});
    for (int i = 0; i < 10; i++)
      vecs.push_back('{8'(8'h30 + i), 1'b0, 8'(8'h86 + i), 8'h00});
    vecs.push_back('{8'h41, 1'b0, 8'h80, 8'h00});
    vecs.push_back('{8'h42, 1'b0, 8'h81, 8'h00});
    vecs.push_back('{8'h43, 1'b0, 8'h82, 8'h00});
    vecs.push_back('{8'h45, 1'b0, 8'h44, 8'h04});
    vecs.push_back('{8'h46, 1'b0, 8'h45, 8'h04});
    vecs.push_back('{8'h30, 1'b0, 8'h46, 8'h04});
    vecs.push_back('{8'h31, 1'b0, 8'hC7, 8'h04});
    vecs.push_back('{8'h61, 1'b0, 8'h67, 8'h08});
    vecs.push_back('{8'h00, 1'b1, 8'h07, 8'h00});

    do_reset();
    check("reset_uo", 32'(uo_out), 32'h00);
    check("reset_uio", 32'(uio_out), 32'h00);
    check("reset_oe", 32'(uio_oe), 32'hFC);

    foreach (vecs[i]) begin
      v = vecs[i];
      if (v.clr_only) begin
        do_clear();
      end else begin
        send(v.ch, 1 + (i % 3), 1'b0);
        model_char(v.ch, 1'b0);
        check($sformatf("vec%0d_pulse", i), 32'(pulses), (dec(v.ch) >= 0) ? 32'd1 : 32'd0);
      end
      check($sformatf("vec%0d_uo", i), 32'(uo_out), 32'(v.uo));
      check($sformatf("vec%0d_uio", i), 32'(uio_out), 32'(v.uio));
    end

    // Strobe held for 100 cycles must yield a single character.
    send_check("hold_b", 8'h42, 100, 1'b0);
    check("hold_b_idx", 32'(uo_out), 32'h01);

    // Error counter saturates at 31.
    for (int i = 0; i < 40; i++) begin
      send(8'(8'h61 + (i % 6)), 1, 1'b0);
      model_char(8'(8'h61 + (i % 6)), 1'b0);
    end
    check("sat_err", 32'(uio_out[6:2]), 32'd31);
    check("sat_uo", 32'(uo_out), 32'(exp_uo()));
    do_clear();
    check("sat_clr_uio", 32'(uio_out), 32'h00);

    // Randomized stream, occasionally with clear held across the character.
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        do_clear();
        check($sformatf("rnd%0d_clr_uo", n), 32'(uo_out), 32'(exp_uo()));
        check($sformatf("rnd%0d_clr_uio", n), 32'(uio_out), 32'(exp_uio()));
      end else begin
        if (r < 13)      ch = alpha[(m_prev + 1) % 16];
        else if (r < 16) ch = alpha[$urandom_range(0, 15)];
        else             ch = 8'($urandom_range(0, 255));
        send_check($sformatf("rnd%0d", n), ch, $urandom_range(1, 4), ($urandom_range(0, 9) == 0));
      end
    end

    // Reset asserted while a strobe is in flight.
    @(posedge clk); #1;
    ui_in = 8'h43;
    uio_in[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_uo", 32'(uo_out), 32'h00);
    check("rst_mid_uio", 32'(uio_out), 32'h00);
    uio_in[0] = 1'b0;
    do_reset();
    send_check("post_rst", 8'h46, 1, 1'b0);

`ifdef UABC_RX_TIMEOUT_EN
    do_reset();
    send_check("tmo_a", 8'h41, 1, 1'b0);
    send_check("tmo_b", 8'h42, 1, 1'b0);
    send_check("tmo_c", 8'h43, 1, 1'b0);
    send_check("tmo_d", 8'h44, 1, 1'b0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("tmo_before", 32'(uo_out[7]), 32'd1);
    repeat (80) @(posedge clk);
    @(negedge clk);
    m_mode = 0; m_tmo = 1; bump();
    check("tmo_uo", 32'(uo_out), 32'(exp_uo()));
    check("tmo_uio", 32'(uio_out), 32'(exp_uio()));
    check("tmo_flag", 32'(uio_out[7]), 32'd1);
    do_clear();
    check("tmo_clr_uio", 32'(uio_out), 32'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
